// File: rtl/neopixel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : neopixel_pkg
// Purpose  : Shared types, default timing constants and the transmit-slot to
//            colour mapping for the NeoPixel controller.
// Revision : 1.0 - initial release
// ============================================================================
package neopixel_pkg;

  // Frame geometry and WS2812 timing at 50 MHz
  localparam int NUM_PIXELS_DEF     = 5;
  localparam int BIT_CYCLES_DEF     = 63;    // 1.25 us per bit
  localparam int T0H_CYCLES_DEF     = 18;    // high time of a 0 bit
  localparam int T1H_CYCLES_DEF     = 35;    // high time of a 1 bit
  localparam int WAIT_CYCLES_DEF    = 2500;  // 50 us latch gap
  localparam int BITS_PER_PIXEL     = 24;
  localparam int COLORS_PER_PIXEL   = 3;

  typedef enum logic [1:0] {
    RED   = 2'd0,
    GREEN = 2'd1,
    BLUE  = 2'd2,
    RSVD  = 2'd3
  } color_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } ctrl_state_t;

  // WS2812 parts expect green first, then red, then blue
  function automatic color_t tx_slot_color(input logic [1:0] slot);
    case (slot)
      2'd0:    tx_slot_color = GREEN;
      2'd1:    tx_slot_color = RED;
      default: tx_slot_color = BLUE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/neo_bit_encoder.sv
`default_nettype none
// ============================================================================
// Module   : neo_bit_encoder
// Purpose  : Produces one WS2812 bit waveform per start strobe: high for the
//            T0H/T1H time, low for the remainder of BIT_CYCLES. Owns the
//            bit-phase counter and flags the last cycle of each bit.
// Revision : 1.0 - initial release
// ============================================================================
module neo_bit_encoder
  import neopixel_pkg::*;
#(
  parameter int BIT_CYCLES = BIT_CYCLES_DEF,
  parameter int T0H_CYCLES = T0H_CYCLES_DEF,
  parameter int T1H_CYCLES = T1H_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic bit_value,
  output logic data,
  output logic bit_done
);

  localparam int                c_PH_W    = $clog2(BIT_CYCLES);
  localparam logic [c_PH_W-1:0] c_PH_LAST = c_PH_W'(BIT_CYCLES - 1);

  logic [c_PH_W-1:0] r_phase;
  logic              r_active;
  logic              r_data;
  logic [31:0]       w_high_cycles;
  logic [31:0]       w_next_phase;

  // bit_value is stable for the whole bit, so the high time can follow it live
  assign w_high_cycles = bit_value ? 32'(T1H_CYCLES) : 32'(T0H_CYCLES);
  assign w_next_phase  = 32'(r_phase) + 32'd1;
  assign bit_done      = r_active && (r_phase == c_PH_LAST);
  assign data          = r_data;

  // Phase counter and registered line level; a start always opens with a high cycle
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_phase  <= '0;
      r_active <= 1'b0;
      r_data   <= 1'b0;
    end else if (start) begin
      r_phase  <= '0;
      r_active <= 1'b1;
      r_data   <= 1'b1;
    end else if (bit_done) begin
      r_phase  <= '0;
      r_active <= 1'b0;
      r_data   <= 1'b0;
    end else if (r_active) begin
      r_phase  <= r_phase + 1'b1;
      r_data   <= (w_next_phase < w_high_cycles);
    end
  end

endmodule
`default_nettype wire

// File: rtl/neopixel_controller.sv
`default_nettype none
// ============================================================================
// Module   : neopixel_controller
// Purpose  : Frame store (NUM_PIXELS x GRB x 8 bit) loaded by a producer in
//            IDLE, then serialised MSB first, pixel 0 first, onto neo_data,
//            followed by the latch wait.
// Options  : NEO_GLOBAL_DIM_EN - adds dim_shift[2:0]; every transmitted byte
//            is level >> dim_shift, captured when send_it is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module neopixel_controller
  import neopixel_pkg::*;
#(
  parameter int NUM_PIXELS  = NUM_PIXELS_DEF,
  parameter int BIT_CYCLES  = BIT_CYCLES_DEF,
  parameter int T0H_CYCLES  = T0H_CYCLES_DEF,
  parameter int T1H_CYCLES  = T1H_CYCLES_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load_color,
  input  logic [2:0] pixel_index,
  input  logic [1:0] color_index,
  input  logic [7:0] color_level,
  input  logic       send_it,
`ifdef NEO_GLOBAL_DIM_EN
  input  logic [2:0] dim_shift,
`endif
  output logic       neo_data,
  output logic       ready_to_load,
  output logic       ready_to_send,
  output logic       begin_send,
  output logic       done_send,
  output logic       done_wait
);

  localparam int c_TOTAL_BITS = BITS_PER_PIXEL * NUM_PIXELS;
  localparam int c_BC_W       = $clog2(c_TOTAL_BITS);
  localparam int c_WT_W       = $clog2(WAIT_CYCLES);
  localparam int c_PIX_W      = $clog2(NUM_PIXELS);

  localparam logic [c_BC_W-1:0] c_BIT_LAST  = c_BC_W'(c_TOTAL_BITS - 1);
  localparam logic [c_BC_W-1:0] c_BPP       = c_BC_W'(BITS_PER_PIXEL);
  localparam logic [c_BC_W-1:0] c_BPB       = c_BC_W'(8);
  localparam logic [c_WT_W-1:0] c_WAIT_LAST = c_WT_W'(WAIT_CYCLES - 1);

  localparam logic [1:0] c_ST_IDLE = IDLE;
  localparam logic [1:0] c_ST_SEND = SEND;
  localparam logic [1:0] c_ST_WAIT = WAIT;

  logic [7:0]        r_store [NUM_PIXELS][COLORS_PER_PIXEL];
  logic [1:0]        r_state;
  logic [c_BC_W-1:0] r_bit_cnt;
  logic [c_WT_W-1:0] r_wait_cnt;
  logic              r_begin_send;
  logic              r_done_send;
  logic [2:0]        r_dim;

  logic              w_idle;
  logic              w_wr_ok;
  logic              w_start_frame;
  logic              w_enc_start;
  logic              w_enc_done;
  logic              w_enc_data;
  logic [c_PIX_W-1:0] w_pix;
  logic [1:0]        w_slot;
  logic [1:0]        w_color;
  logic [7:0]        w_byte;
  logic              w_bit_value;

  assign w_idle        = (r_state == c_ST_IDLE);
  assign w_wr_ok       = load_color && (32'(pixel_index) < 32'(NUM_PIXELS)) &&
                         (color_index != 2'(RSVD));
  assign w_start_frame = w_idle && send_it;
  // Reload the encoder at every bit boundary except after the final bit
  assign w_enc_start   = w_start_frame ||
                         ((r_state == c_ST_SEND) && w_enc_done && (r_bit_cnt != c_BIT_LAST));

  // Current bit: pixel = n/24, colour slot = (n%24)/8, MSB first within the byte
  assign w_pix       = c_PIX_W'(r_bit_cnt / c_BPP);
  assign w_slot      = 2'((r_bit_cnt % c_BPP) / c_BPB);
  assign w_color     = tx_slot_color(w_slot);
  assign w_byte      = r_store[w_pix][w_color] >> r_dim;
  assign w_bit_value = w_byte[~r_bit_cnt[2:0]];

  assign neo_data      = w_enc_data;
  assign ready_to_load = w_idle;
  assign ready_to_send = w_idle;
  assign begin_send    = r_begin_send;
  assign done_send     = r_done_send;
  assign done_wait     = (r_state == c_ST_WAIT) && (r_wait_cnt == c_WAIT_LAST);

  // Frame store: written only in IDLE, so the transmitter reads it without a snapshot
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PIXELS; p++) begin
        for (int c = 0; c < COLORS_PER_PIXEL; c++) begin
          r_store[p][c] <= 8'h00;
        end
      end
    end else if (w_idle && w_wr_ok) begin
      r_store[pixel_index[c_PIX_W-1:0]][color_index] <= color_level;
    end
  end

  // Global dim amount, frozen for the frame at the send_it cycle
`ifdef NEO_GLOBAL_DIM_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_dim <= 3'd0;
    end else if (w_start_frame) begin
      r_dim <= dim_shift;
    end
  end
`else
  assign r_dim = 3'd0;
`endif

  // Frame sequencer: IDLE -> SEND (120 bits) -> WAIT (latch gap) -> IDLE
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= c_ST_IDLE;
      r_bit_cnt    <= '0;
      r_wait_cnt   <= '0;
      r_begin_send <= 1'b0;
      r_done_send  <= 1'b0;
    end else begin
      r_begin_send <= 1'b0;
      r_done_send  <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (send_it) begin
            r_state      <= c_ST_SEND;
            r_bit_cnt    <= '0;
            r_begin_send <= 1'b1;
          end
        end
        c_ST_SEND: begin
          if (w_enc_done) begin
            if (r_bit_cnt == c_BIT_LAST) begin
              r_state     <= c_ST_WAIT;
              r_wait_cnt  <= '0;
              r_done_send <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        c_ST_WAIT: begin
          if (r_wait_cnt == c_WAIT_LAST) begin
            r_state    <= c_ST_IDLE;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  neo_bit_encoder #(
    .BIT_CYCLES (BIT_CYCLES),
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES)
  ) u_encoder (
    .clock     (clock),
    .reset     (reset),
    .start     (w_enc_start),
    .bit_value (w_bit_value),
    .data      (w_enc_data),
    .bit_done  (w_enc_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_neopixel_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_neopixel_controller
// Purpose  : Directed self-checking bench for neopixel_controller. Build with
//            NEO_GLOBAL_DIM_EN to include the dim_shift port and its test.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neopixel_controller;

  localparam int NPIX  = 5;
  localparam int BITC  = 63;
  localparam int T0H   = 18;
  localparam int T1H   = 35;
  localparam int WAITC = 2500;
  localparam int NBITS = 24 * NPIX;

  logic       clock = 1'b0;
  logic       reset;
  logic       load_color;
  logic [2:0] pixel_index;
  logic [1:0] color_index;
  logic [7:0] color_level;
  logic       send_it;
`ifdef NEO_GLOBAL_DIM_EN
  logic [2:0] dim_shift;
`endif
  logic       neo_data;
  logic       ready_to_load;
  logic       ready_to_send;
  logic       begin_send;
  logic       done_send;
  logic       done_wait;

  int         vec_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] exp_store [NPIX][3];
  int         exp_dim = 0;

  always #5 clock = ~clock;

  neopixel_controller dut (
    .clock         (clock),
    .reset         (reset),
    .load_color    (load_color),
    .pixel_index   (pixel_index),
    .color_index   (color_index),
    .color_level   (color_level),
    .send_it       (send_it),
`ifdef NEO_GLOBAL_DIM_EN
    .dim_shift     (dim_shift),
`endif
    .neo_data      (neo_data),
    .ready_to_load (ready_to_load),
    .ready_to_send (ready_to_send),
    .begin_send    (begin_send),
    .done_send     (done_send),
    .done_wait     (done_wait)
  );

  task automatic chk(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_model();
    for (int p = 0; p < NPIX; p++)
      for (int c = 0; c < 3; c++)
        exp_store[p][c] = 8'h00;
  endtask

  // Expected value of frame bit b: pixel-major, G/R/B order, MSB first
  function automatic bit exp_bit(input int b);
    int         pix, slot, col;
    logic [7:0] byte_v;
    pix    = b / 24;
    slot   = (b % 24) / 8;
    col    = (slot == 0) ? 1 : (slot == 1) ? 0 : 2;
    byte_v = exp_store[pix][col] >> exp_dim;
    return byte_v[7 - (b % 8)];
  endfunction

  task automatic load(input int p, input int c, input int v);
    load_color  = 1'b1;
    pixel_index = 3'(p);
    color_index = 2'(c);
    color_level = 8'(v);
    tick();
    load_color = 1'b0;
    if (p < NPIX && c != 3) exp_store[p][c] = 8'(v);
  endtask

  // Issues send_it and checks the whole frame; abort_bit >= 0 resets at that bit
  task automatic run_frame(input bit blk, input int abort_bit);
    int hi [NBITS];
    int b, ph, h;
    int shape_err = 0, pulse_err = 0, rdy_err = 0, wait_err = 0;
    send_it = 1'b1;
    tick();
    send_it    = 1'b0;
    load_color = 1'b0;
`ifdef NEO_GLOBAL_DIM_EN
    dim_shift = 3'd0;
`endif
    for (int k = 0; k < NBITS * BITC; k++) begin
      b  = k / BITC;
      ph = k % BITC;
      if (abort_bit >= 0 && k == abort_bit * BITC) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("abort_neo", neo_data, 0);
        chk("abort_rdy_load", ready_to_load, 1);
        chk("abort_rdy_send", ready_to_send, 1);
        return;
      end
      if (k == 0) chk("begin_send", begin_send, 1);
      else        pulse_err += int'(begin_send);
      pulse_err += int'(done_send) + int'(done_wait);
      rdy_err   += int'(ready_to_load) + int'(ready_to_send);
      h = exp_bit(b) ? T1H : T0H;
      if (ph == 0) hi[b] = 0;
      hi[b] += int'(neo_data);
      if (neo_data != (ph < h)) shape_err++;
      if (blk && k == 1000) begin
        load_color  = 1'b1;
        pixel_index = 3'd0;
        color_index = 2'd1;
        color_level = 8'hFF;
      end
      if (blk && k == 1001) load_color = 1'b0;
      tick();
    end
    for (int i = 0; i < NBITS; i++)
      chk($sformatf("bit%0d_high", i), hi[i], exp_bit(i) ? T1H : T0H);
    chk("send_shape_errs", shape_err, 0);
    chk("send_pulse_errs", pulse_err, 0);
    chk("send_ready_errs", rdy_err, 0);
    for (int k = 0; k < WAITC; k++) begin
      if (k == 0) chk("done_send", done_send, 1);
      else        wait_err += int'(done_send);
      if (k == WAITC - 1) chk("done_wait", done_wait, 1);
      else                wait_err += int'(done_wait);
      wait_err += int'(neo_data) + int'(begin_send) +
                  int'(ready_to_load) + int'(ready_to_send);
      if (blk && k == 100) send_it = 1'b1;
      if (blk && k == 101) send_it = 1'b0;
      tick();
    end
    chk("wait_errs", wait_err, 0);
    chk("idle_rdy_load", ready_to_load, 1);
    chk("idle_rdy_send", ready_to_send, 1);
    chk("idle_begin", begin_send, 0);
    chk("idle_done_wait", done_wait, 0);
    chk("idle_neo", neo_data, 0);
  endtask

  initial begin
    reset       = 1'b0;
    load_color  = 1'b0;
    pixel_index = 3'd0;
    color_index = 2'd0;
    color_level = 8'h00;
    send_it     = 1'b0;
`ifdef NEO_GLOBAL_DIM_EN
    dim_shift = 3'd0;
`endif
    clear_model();
    repeat (3) tick();
    chk("rst_neo", neo_data, 0);
    chk("rst_rdy_load", ready_to_load, 1);
    chk("rst_rdy_send", ready_to_send, 1);
    chk("rst_begin", begin_send, 0);
    chk("rst_done_send", done_send, 0);
    chk("rst_done_wait", done_wait, 0);
    reset = 1'b1;

    // All-zero frame straight after reset
    run_frame(1'b0, -1);

    // Pixel 0 red = 0x80: only bit 8 is a 1
    load(0, 0, 8'h80);
    run_frame(1'b0, -1);

    // Clear red, illegal writes dropped, then load pixel 4 blue with send_it
    load(0, 0, 8'h00);
    load(5, 1, 8'hFF);
    load(7, 0, 8'hFF);
    load(2, 3, 8'hFF);
    load_color  = 1'b1;
    pixel_index = 3'd4;
    color_index = 2'd2;
    color_level = 8'h01;
    exp_store[4][2] = 8'h01;
    run_frame(1'b1, -1);

    // Second frame: blocked write and ignored send_it left the store intact
    run_frame(1'b0, -1);

    // Reset at bit 50, then the store must come back cleared
    run_frame(1'b0, 50);
    clear_model();
`ifdef NEO_GLOBAL_DIM_EN
    load(1, 1, 8'hFF);
    dim_shift = 3'd2;
    exp_dim   = 2;
`endif
    run_frame(1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
